cook_controller: RTL and testbench

Front-end controller that drives the BCD countdown timer (seconds ones, seconds tens, minutes) from the user side. It turns keypad digits into timer load pulses, sequences start/stop/clear/door events through a state machine, generates the 1 Hz count enable from the system clock, and switches the magnetron off when the timer reports zero. It is the writer/initiator for the timer's `data`/`loadn`/`clrn`/`enable` inputs and the reader of its `zero` output.

---
 rtl/cook_controller_if.sv | 34 +++
 rtl/cook_controller.sv | 156 +++++++++++++++
 tb/tb_cook_controller.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cook_controller_if.sv
// User/timer side bundle of the cook controller: keypad, commands, door and timer status in,
// timer drive strobes, magnetron drive and status out.
// No latency or backpressure of its own; all handshakes are one-cycle pulses.
// Ports: key_valid/key_digit keypad, start/stop/clear commands, door_closed and timer_zero levels,
//        data/loadn/timer_clrn/enable towards the timer, mag_on/done/state/digit_count status.
interface cook_controller_if;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop;
    logic       clear;
    logic       door_closed;
    logic       timer_zero;
    logic [3:0] data;
    logic       loadn;
    logic       timer_clrn;
    logic       enable;
    logic       mag_on;
    logic       done;
    logic [2:0] state;
    logic [1:0] digit_count;

    // Controller side.
    modport slave (
        input  key_valid, key_digit, start, stop, clear, door_closed, timer_zero,
        output data, loadn, timer_clrn, enable, mag_on, done, state, digit_count
    );

    // User/environment side.
    modport master (
        output key_valid, key_digit, start, stop, clear, door_closed, timer_zero,
        input  data, loadn, timer_clrn, enable, mag_on, done, state, digit_count
    );
endinterface

// File: rtl/cook_controller.sv
// Purpose: keypad/command front end for a BCD countdown timer, with 1 Hz-style tick prescaler and magnetron control.
// Latency: every output is registered; commands sampled at edge n take effect in cycle n+1.
// Backpressure: none; inputs are single-cycle pulses/levels and ignored keys or commands are simply dropped.
// Ports: clock, clrn (async active-low reset), bus (cook_controller_if.slave) carrying keypad,
//        start/stop/clear, door/timer status in and data/loadn/timer_clrn/enable/mag_on/done/state/digit_count out.
module cook_controller #(
    parameter int TICK_DIV = 50000000
) (
    input  logic             clock,
    input  logic             clrn,
    cook_controller_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int             PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic [3:0]    data_q, data_d;
    logic [1:0]    digit_count_q, digit_count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          loadn_q, loadn_d;
    logic          timer_clrn_q, timer_clrn_d;
    logic          enable_q, enable_d;
    logic          mag_on_q, mag_on_d;
    logic          done_q, done_d;

    // One-cycle events produced by the next-state logic, turned into strobes by the output logic.
    logic          load_evt;
    logic          clr_evt;
    logic          tick_evt;

    logic          key_ok;
    logic          do_clear;

    assign key_ok   = bus.key_valid && (bus.key_digit <= 4'd9) && (digit_count_q != 2'd3);
    // Clear is honoured everywhere except while the magnetron is running.
    assign do_clear = bus.clear && (state_q != ST_COOK);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_q       <= ST_IDLE;
            data_q        <= 4'd0;
            digit_count_q <= 2'd0;
            presc_q       <= '0;
            loadn_q       <= 1'b1;
            timer_clrn_q  <= 1'b1;
            enable_q      <= 1'b0;
            mag_on_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            digit_count_q <= digit_count_d;
            presc_q       <= presc_d;
            loadn_q       <= loadn_d;
            timer_clrn_q  <= timer_clrn_d;
            enable_q      <= enable_d;
            mag_on_q      <= mag_on_d;
            done_q        <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Priority within IDLE/SET is clear > start > key:
    // a start that is actually taken swallows a key in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        digit_count_d = digit_count_q;
        presc_d       = presc_q;
        load_evt      = 1'b0;
        clr_evt       = 1'b0;
        tick_evt      = 1'b0;

        if (do_clear) begin
            state_d       = ST_IDLE;
            digit_count_d = 2'd0;
            presc_d       = '0;
            clr_evt       = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_SET: begin
                    if (bus.start && (state_q == ST_SET) && bus.door_closed && !bus.timer_zero) begin
                        state_d = ST_COOK;
                        presc_d = '0;
                    end else if (key_ok) begin
                        state_d       = ST_SET;
                        data_d        = bus.key_digit;
                        digit_count_d = digit_count_q + 2'd1;
                        load_evt      = 1'b1;
                    end
                end
                ST_COOK: begin
                    // On any exit the prescaler is frozen so a resume continues the partial period.
                    if (bus.timer_zero) begin
                        state_d = ST_DONE;
                    end else if (!bus.door_closed || bus.stop) begin
                        state_d = ST_PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d  = '0;
                        tick_evt = 1'b1;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    // stop beats a simultaneous start.
                    if (bus.start && !bus.stop && bus.door_closed) begin
                        state_d = ST_COOK;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic: values registered into the output flops next edge.
    // Deriving mag_on/done from the next state makes them switch in the
    // same cycle the state register does.
    // ------------------------------------------------------------------
    always_comb begin
        loadn_d      = !load_evt;
        timer_clrn_d = !clr_evt;
        enable_d     = tick_evt;
        mag_on_d     = (state_d == ST_COOK);
        done_d       = (state_d == ST_DONE);
    end

    assign bus.data        = data_q;
    assign bus.loadn       = loadn_q;
    assign bus.timer_clrn  = timer_clrn_q;
    assign bus.enable      = enable_q;
    assign bus.mag_on      = mag_on_q;
    assign bus.done        = done_q;
    assign bus.state       = state_q;
    assign bus.digit_count = digit_count_q;

endmodule

// File: tb/tb_cook_controller.sv
// Bench for cook_controller with TICK_DIV=4: directed stimulus pushes expected timer strobes
// (load/clear/tick with data and cycle) into a queue; a negedge monitor pops and compares them.
// State and level outputs are checked directly against hand-derived values.
module tb_cook_controller;

    localparam int TD = 4;
    localparam int EV_KEY = 0;
    localparam int EV_CLR = 1;
    localparam int EV_ENA = 2;

    typedef struct {
        int         kind;
        logic [3:0] dat;
        int         cyc;
    } ev_t;

    logic clock = 1'b0;
    logic clrn  = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    ev_t  exp_q[$];

    cook_controller_if bus();

    cook_controller #(.TICK_DIV(TD)) dut (
        .clock (clock),
        .clrn  (clrn),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [3:0] dat, input int c);
        ev_t e;
        e.kind = kind;
        e.dat  = dat;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Scoreboard side: called by the monitor whenever a strobe is seen.
    task automatic sb_observe(input int kind, input logic [3:0] dat);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: kind %0d data %0d at cycle %0d, expected none", kind, dat, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.dat != dat || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL event: got kind %0d data %0d cycle %0d, expected kind %0d data %0d cycle %0d",
                         kind, dat, cyc, e.kind, e.dat, e.cyc);
            end
        end
    endtask

    always @(negedge clock) begin
        if (clrn) begin
            if (!bus.loadn)      sb_observe(EV_KEY, bus.data);
            if (!bus.timer_clrn) sb_observe(EV_CLR, 4'd0);
            if (bus.enable)      sb_observe(EV_ENA, 4'd0);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic press(input logic [3:0] d, input bit acc);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        if (acc) push(EV_KEY, d, cyc + 1);
        step();
        bus.key_valid = 1'b0;
    endtask

    task automatic cmd(input bit s, input bit p, input bit c);
        bus.start = s;
        bus.stop  = p;
        bus.clear = c;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.clear = 1'b0;
    endtask

    initial begin
        int s;
        int r;
        bus.key_valid   = 1'b0;
        bus.key_digit   = 4'd0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.clear       = 1'b0;
        bus.door_closed = 1'b1;
        bus.timer_zero  = 1'b0;

        // Reset values.
        #23;
        check("rst_state", bus.state, 0);
        check("rst_data", bus.data, 0);
        check("rst_count", bus.digit_count, 0);
        check("rst_loadn", bus.loadn, 1);
        check("rst_timer_clrn", bus.timer_clrn, 1);
        check("rst_enable", bus.enable, 0);
        check("rst_mag_on", bus.mag_on, 0);
        check("rst_done", bus.done, 0);
        step();
        clrn = 1'b1;
        step();

        // Out-of-range digit in IDLE is dropped.
        press(4'd12, 1'b0);
        check("key12_state", bus.state, 0);
        check("key12_count", bus.digit_count, 0);

        // Three digits accepted back to back, a fourth is refused.
        press(4'd1, 1'b1);
        check("key1_state", bus.state, 1);
        press(4'd3, 1'b1);
        press(4'd0, 1'b1);
        press(4'd5, 1'b0);
        check("keys_count", bus.digit_count, 3);
        check("keys_state", bus.state, 1);

        // start refused while the timer already reads zero.
        bus.timer_zero = 1'b1;
        cmd(1, 0, 0);
        bus.timer_zero = 1'b0;
        check("start_tz_state", bus.state, 1);

        // Cook to completion: ticks 4, 8, 12 cycles after entry.
        s = cyc;
        push(EV_ENA, 4'd0, s + 1 + TD);
        push(EV_ENA, 4'd0, s + 1 + 2 * TD);
        push(EV_ENA, 4'd0, s + 1 + 3 * TD);
        cmd(1, 0, 0);
        check("cook_state", bus.state, 2);
        check("cook_mag_on", bus.mag_on, 1);
        wait_until(s + 6);
        cmd(0, 0, 1);
        check("clear_in_cook_state", bus.state, 2);
        wait_until(s + 14);
        bus.timer_zero = 1'b1;
        step();
        bus.timer_zero = 1'b0;
        check("done_state", bus.state, 4);
        check("done_mag_on", bus.mag_on, 0);
        check("done_done", bus.done, 1);
        check("done_enable", bus.enable, 0);
        press(4'd4, 1'b0);
        check("key_in_done_state", bus.state, 4);
        cmd(1, 0, 0);
        check("start_in_done_state", bus.state, 4);
        push(EV_CLR, 4'd0, cyc + 1);
        cmd(0, 0, 1);
        check("clear_done_state", bus.state, 0);
        check("clear_done_done", bus.done, 0);
        check("clear_done_count", bus.digit_count, 0);

        // Door opened with prescaler at 2, then resumed: tick 2 cycles after re-entry.
        press(4'd2, 1'b1);
        s = cyc;
        cmd(1, 0, 0);
        check("door_cook_state", bus.state, 2);
        wait_until(s + 3);
        bus.door_closed = 1'b0;
        step();
        check("door_pause_state", bus.state, 3);
        check("door_pause_mag_on", bus.mag_on, 0);
        step();
        step();
        step();
        cmd(1, 0, 0);
        check("start_door_open_state", bus.state, 3);
        bus.door_closed = 1'b1;
        r = cyc;
        push(EV_ENA, 4'd0, r + 3);
        cmd(1, 0, 0);
        check("resume_state", bus.state, 2);
        check("resume_mag_on", bus.mag_on, 1);
        wait_until(r + 4);
        cmd(0, 1, 0);
        check("stop_state", bus.state, 3);
        cmd(1, 1, 0);
        check("stop_start_state", bus.state, 3);
        step();
        push(EV_CLR, 4'd0, cyc + 1);
        cmd(0, 0, 1);
        check("clear_pause_state", bus.state, 0);
        check("clear_pause_count", bus.digit_count, 0);

        // start in IDLE is ignored.
        cmd(1, 0, 0);
        check("start_idle_state", bus.state, 0);

        // clear + start + key together in SET: clear wins, no load.
        press(4'd7, 1'b1);
        bus.key_valid = 1'b1;
        bus.key_digit = 4'd4;
        push(EV_CLR, 4'd0, cyc + 1);
        cmd(1, 0, 1);
        bus.key_valid = 1'b0;
        check("combo_state", bus.state, 0);
        check("combo_count", bus.digit_count, 0);

        // Asynchronous reset in the middle of cooking.
        press(4'd9, 1'b1);
        cmd(1, 0, 0);
        check("pre_rst_state", bus.state, 2);
        step();
        step();
        #2;
        clrn = 1'b0;
        #1;
        check("async_rst_state", bus.state, 0);
        check("async_rst_mag_on", bus.mag_on, 0);
        check("async_rst_count", bus.digit_count, 0);
        step();
        clrn = 1'b1;
        step();
        step();
        check("post_rst_state", bus.state, 0);

        check("sb_leftover", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
